// File: rtl/gpio_cfg_slave.sv
// rtl/gpio_cfg_slave.sv - PS GPIO config bus responder: synchronize, settle, write, read back, ack
module gpio_cfg_slave #(
   parameter int GPIO_W      = 32,
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 8,
   parameter int WCLK_BIT    = 24,
   parameter int SYNC_STAGES = 2,
   parameter int SETTLE      = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [GPIO_W-1:0] gpio_in,
   output logic [GPIO_W-1:0] gpio_out,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              overrun,
   output logic [15:0]       txn_count
);
   localparam int DATA_LSB = 16;
   localparam int CNT_W = $clog2(SETTLE + 1);
   localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_WRITE,
      ST_READ,
      ST_CAPT,
      ST_DONE
   } state_t;

   logic [GPIO_W-1:0] sync_q [SYNC_STAGES];
   logic              strobe_q;
   state_t            state_q;
   logic [ADDR_W-1:0] shadow_addr_q;
   logic [DATA_W-1:0] shadow_data_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [DATA_W-1:0] wr_data_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;
   logic [GPIO_W-1:0] gpio_q;
   logic              wr_en_q;
   logic              rd_en_q;
   logic              overrun_q;
   logic [15:0]       txn_q;
   logic [15:0]       txn_d;

   logic [ADDR_W-1:0] s_addr;
   logic [DATA_W-1:0] s_data;
   logic              s_strb;
   logic              rise;
   logic              in_flight;
   logic              same;

   assign s_addr    = sync_q[SYNC_STAGES-1][ADDR_W-1:0];
   assign s_data    = sync_q[SYNC_STAGES-1][DATA_LSB +: DATA_W];
   assign s_strb    = sync_q[SYNC_STAGES-1][WCLK_BIT];
   assign rise      = s_strb & ~strobe_q;
   assign in_flight = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign same      = (s_addr == shadow_addr_q) && (s_data == shadow_data_q);
   assign cnt_d     = cnt_q + CNT_W'(1);
   assign txn_d     = txn_q + 16'd1;

   // Whole bus goes through the chain; addr/data are only trusted after SETTLE matching samples.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         strobe_q <= 1'b0;
      end else begin
         sync_q[0] <= gpio_in;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         strobe_q <= s_strb;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         shadow_addr_q <= '0;
         shadow_data_q <= '0;
         wr_addr_q     <= '0;
         wr_data_q     <= '0;
         cnt_q         <= '0;
         gpio_q        <= '0;
         wr_en_q       <= 1'b0;
         rd_en_q       <= 1'b0;
         overrun_q     <= 1'b0;
         txn_q         <= '0;
      end else begin
         wr_en_q <= 1'b0;
         rd_en_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (rise) begin
                  shadow_addr_q <= s_addr;
                  shadow_data_q <= s_data;
                  cnt_q         <= '0;
                  state_q       <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (!s_strb) begin
                  state_q <= ST_IDLE;
               end else if (!same) begin
                  shadow_addr_q <= s_addr;
                  shadow_data_q <= s_data;
                  cnt_q         <= '0;
               end else if (cnt_d == SETTLE_CNT) begin
                  wr_addr_q <= shadow_addr_q;
                  wr_data_q <= shadow_data_q;
                  wr_en_q   <= 1'b1;
                  state_q   <= ST_WRITE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            ST_WRITE: begin
               rd_en_q <= 1'b1;
               state_q <= ST_READ;
            end
            ST_READ: begin
               state_q <= ST_CAPT;
            end
            ST_CAPT: begin
               gpio_q                       <= '0;
               gpio_q[ADDR_W-1:0]           <= wr_addr_q;
               gpio_q[DATA_LSB +: DATA_W]   <= rd_data;
               gpio_q[WCLK_BIT]             <= 1'b1;
               txn_q                        <= txn_d;
               state_q                      <= ST_DONE;
            end
            ST_DONE: begin
               if (!s_strb) begin
                  gpio_q[WCLK_BIT] <= 1'b0;
                  state_q          <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
         // A second host edge mid-transaction is flagged but never restarts the sequence.
         if (rise && in_flight) overrun_q <= 1'b1;
      end
   end

   assign gpio_out  = gpio_q;
   assign wr_en     = wr_en_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign rd_en     = rd_en_q;
   assign rd_addr   = wr_addr_q;
   assign busy      = in_flight;
   assign overrun   = overrun_q;
   assign txn_count = txn_q;
endmodule

// File: doc/gpio_cfg_slave.md
# gpio_cfg_slave

Fabric-side responder for the PS GPIO configuration bus. The host drives address (bits 15:0), data (bits 23:16) and a write strobe (bit 24) on a 32-bit GPIO output. This block synchronizes that bus into the fabric clock, detects each strobe rising edge and issues one register-file write. It then reads back the same address and returns the result on the GPIO input bus, with an acknowledge bit for a four-phase handshake.

## Interface
Parameters:
- GPIO_W, 32, GPIO bus width
- ADDR_W, 16, address width (GPIO bits ADDR_W-1:0)
- DATA_W, 8, data width (GPIO bits 16+DATA_W-1:16)
- WCLK_BIT, 24, strobe/ack bit position
- SYNC_STAGES, 2, synchronizer depth (≥2)
- SETTLE, 2, consecutive identical addr/data samples required before write (≥1)

Ports:
- clk  in  1  fabric clock; single clock domain
- rst  in  1  asynchronous, active-low reset
- gpio_in  in  GPIO_W  host GPIO output, asynchronous to clk
- gpio_out  out  GPIO_W  to host GPIO input: [ADDR_W-1:0] echoed addr, [23:16] read data, [24] ack, others 0
- wr_en  out  1  one-cycle write strobe to the register file
- wr_addr  out  ADDR_W  write address, held until the next transaction
- wr_data  out  DATA_W  write data, held until the next transaction
- rd_en  out  1  one-cycle read strobe
- rd_addr  out  ADDR_W  equals wr_addr
- rd_data  in  DATA_W  register-file read data, valid the cycle after rd_en
- busy  out  1  high in any state other than IDLE and DONE
- overrun  out  1  sticky; a strobe rising edge was seen while busy
- txn_count  out  16  completed transactions, wraps at 65535→0

## Operation
- All GPIO_W bits pass through a SYNC_STAGES flop chain. All logic uses the synchronized copy `s`. A registered copy `s_q` of `s[WCLK_BIT]` is kept for edge detection.
- Rising edge: `s[WCLK_BIT]=1` and `s_q=0`.
- FSM states:
  - IDLE: on a rising edge, capture `s` addr/data into the shadow regs, clear the stable counter, go to SETTLE.
  - SETTLE: each cycle compare `s` addr/data with the shadow.
    - Match: increment the counter.
    - Mismatch: reload the shadow and clear the counter.
    - When the counter reaches SETTLE: go to WRITE.
    - If `s[WCLK_BIT]` falls before that point, abort to IDLE. No write, no ack.
  - WRITE: load wr_addr/wr_data from the shadow, pulse wr_en. Go to READ.
  - READ: pulse rd_en (rd_addr = wr_addr). Go to CAPT.
  - CAPT: register rd_data into gpio_out[23:16] and wr_addr into gpio_out[ADDR_W-1:0]. Set ack. Increment txn_count. Go to DONE.
  - DONE: hold ack=1 until `s[WCLK_BIT]=0`, then clear ack and go to IDLE.
- Every transaction performs both a write and a readback. Read-only addresses ignore the write in the register file. The host reads a readback register by issuing a transaction to that address with any data.
- A rising edge in SETTLE/WRITE/READ/CAPT sets overrun and is otherwise ignored.
  - A new edge cannot occur in DONE, because the strobe must first fall.
- overrun clears only on reset.

## Timing
- Reset values: gpio_out=0, wr_en=0, rd_en=0, wr_addr=0, wr_data=0, busy=0, overrun=0, txn_count=0, FSM=IDLE, synchronizer and `s_q` = 0.
- Let cycle E be the edge-detect cycle. E is SYNC_STAGES cycles after the gpio_in change is first sampled.
- With stable inputs:
  - SETTLE occupies E+1 .. E+SETTLE.
  - wr_en is high at E+SETTLE+1.
  - rd_en is high at E+SETTLE+2.
  - rd_data is sampled at the end of E+SETTLE+3.
  - ack and gpio_out data are valid at E+SETTLE+4. Default: E+6.
- Each addr/data mismatch in SETTLE extends the latency by the cycles spent re-settling.
- ack falls one cycle after `s[WCLK_BIT]` is observed low in DONE.
- Host rule: hold addr/data stable from the strobe rise until ack is seen, then drop the strobe and wait for ack low.
- wr_en and rd_en are never high in the same cycle. Each is exactly one cycle wide.
- txn_count wraps 0xFFFF→0x0000 silently.
- Asynchronous reset mid-transaction returns to IDLE immediately with no write pulse. If the strobe is still high after reset release, `s_q` starts at 0, so a new edge is detected once the synchronizer fills.

## Test plan
- Basic write: addr=0x0004, data=0x5A, strobe up -> wr_en single pulse, wr_addr=0x0004, wr_data=0x5A; rd_data model returns 0x5A -> gpio_out[23:16]=0x5A, [15:0]=0x0004, [24]=1 at E+6; strobe down -> ack 0; txn_count=1.
- Readback: rd_data model returns 0xC3 for addr 0x0012 -> gpio_out[23:16]=0xC3 while ack=1.
- Settling: data changes 0x11→0x22 one cycle after the strobe rises -> a single wr_en with wr_data=0x22, one cycle later than nominal.
- Glitch abort: strobe high for 2 synchronized cycles, then low, SETTLE=4 -> no wr_en, no ack, txn_count unchanged.
- Overrun: force a second rising edge while in READ -> overrun=1 and stays high; exactly one write occurs.
- Reset/wrap: assert rst during SETTLE -> all outputs 0, no wr_en; preload txn_count to 0xFFFF and run one transaction -> 0x0000.
